// File: rtl/mbq_pkg.sv
// rtl/mbq_pkg.sv - shared width helpers and lane ordering for the down-converting queue
// Purpose: constant-evaluable helpers used by the interface, the RAM wrapper and the top.
//   mbq_clog2      : ceiling log2 for parameter derivation
//   mbq_in_width   : wide entry width from lane width and ratio
//   mbq_lane_index : physical lane slot for the n-th lane read out of an entry
package mbq_pkg;

  function automatic int mbq_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int mbq_in_width(input int out_width, input int ratio);
    return out_width * ratio;
  endfunction

  // With lsb_first clear, the first lane read is the most significant slice.
  function automatic int mbq_lane_index(input int lane, input int ratio, input bit lsb_first);
    return lsb_first ? lane : (ratio - 1 - lane);
  endfunction

endpackage

// File: rtl/multibuffer_queue_gen2_if.sv
// rtl/multibuffer_queue_gen2_if.sv - wide write bus, narrow read bus and status of the queue
// Purpose: bundles every non-clock/reset signal of multibuffer_queue_gen2.
//   master : the producer/consumer side (drives write_en/data_in/data_lanes/read_en/flush)
//   slave  : the queue itself (drives waitrequest/data_out/data_valid/flags/level)
interface multibuffer_queue_gen2_if #(
  parameter int OUT_WIDTH  = 64,
  parameter int RATIO      = 2,
  parameter int ADDR_WIDTH = 4
);
  import mbq_pkg::*;

  localparam int LANE_W   = mbq_clog2(RATIO + 1);
  localparam int IN_WIDTH = mbq_in_width(OUT_WIDTH, RATIO);

  logic                  flush;
  logic                  write_en;
  logic [IN_WIDTH-1:0]   data_in;
  logic [LANE_W-1:0]     data_lanes;
  logic                  waitrequest;
  logic                  read_en;
  logic [OUT_WIDTH-1:0]  data_out;
  logic                  data_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow;

  modport master (
    output flush, write_en, data_in, data_lanes, read_en,
    input  waitrequest, data_out, data_valid, full, empty, almost_full, level, overflow
  );

  modport slave (
    input  flush, write_en, data_in, data_lanes, read_en,
    output waitrequest, data_out, data_valid, full, empty, almost_full, level, overflow
  );

endinterface

// File: rtl/mbq_ram.sv
// rtl/mbq_ram.sv - simple dual-port entry store, synchronous write, asynchronous read
// Purpose: holds DEPTH entries of {lane count, wide data}.
//   clk   : write clock
//   we    : write enable, waddr/wdata : write port
//   raddr : read address, rdata : combinational read data
module mbq_ram #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/multibuffer_queue_gen2.sv
// rtl/multibuffer_queue_gen2.sv - down-converting queue: wide entries in, one lane per read out
// Purpose: stores up to 2**ADDR_WIDTH entries of RATIO lanes (or fewer, per data_lanes) and
//   returns them one OUT_WIDTH lane per accepted read, in LSB_FIRST-selected order.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of multibuffer_queue_gen2_if (write bus, read bus, flush, status)
module multibuffer_queue_gen2
  import mbq_pkg::*;
#(
  parameter int OUT_WIDTH  = 64,
  parameter int RATIO      = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_MARGIN  = 2,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  multibuffer_queue_gen2_if.slave  bus
);

  localparam int LANE_W   = mbq_clog2(RATIO + 1);
  localparam int IN_WIDTH = mbq_in_width(OUT_WIDTH, RATIO);
  localparam int DEPTH    = 2 ** ADDR_WIDTH;
  localparam int ENTRY_W  = IN_WIDTH + LANE_W;

  localparam logic [ADDR_WIDTH:0] DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_L      = (ADDR_WIDTH + 1)'(DEPTH - AF_MARGIN);
  localparam logic [LANE_W-1:0]   RATIO_L   = LANE_W'(RATIO);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [LANE_W-1:0]   LANE_ONE  = LANE_W'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   level;
  logic [LANE_W-1:0]     lane_cnt;
  logic [OUT_WIDTH-1:0]  data_out;
  logic                  data_valid;
  logic                  overflow;

  logic                  full, empty;
  logic                  push, pop_lane, pop_entry;
  logic [LANE_W-1:0]     wr_lanes;
  logic [ENTRY_W-1:0]    head;
  logic [IN_WIDTH-1:0]   head_data;
  logic [LANE_W-1:0]     head_lanes;
  int                    lane_idx;
  logic [OUT_WIDTH-1:0]  lane_data;

  // Flags come from the registered level only, so a pop in the same cycle never frees a slot.
  assign full  = (level == DEPTH_L);
  assign empty = (level == '0);

  assign push      = bus.write_en && !full && !bus.flush;
  assign pop_lane  = bus.read_en && !empty && !bus.flush;
  assign pop_entry = pop_lane && (lane_cnt == head_lanes - LANE_ONE);

  // Out-of-range lane counts are normalised once at write time.
  assign wr_lanes = ((bus.data_lanes == '0) || (bus.data_lanes > RATIO_L)) ? RATIO_L : bus.data_lanes;

  mbq_ram #(
    .WIDTH      (ENTRY_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({wr_lanes, bus.data_in}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign head_data  = head[IN_WIDTH-1:0];
  assign head_lanes = head[ENTRY_W-1:IN_WIDTH];

  always_comb begin
    lane_idx  = mbq_lane_index(int'(lane_cnt), RATIO, LSB_FIRST);
    lane_data = head_data[lane_idx*OUT_WIDTH +: OUT_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      lane_cnt   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      lane_cnt   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (bus.write_en && full) overflow <= 1'b1;
      data_valid <= pop_lane;
      if (pop_lane) begin
        data_out <= lane_data;
        if (pop_entry) begin
          lane_cnt <= '0;
          rd_ptr   <= rd_ptr + PTR_ONE;
        end else begin
          lane_cnt <= lane_cnt + LANE_ONE;
        end
      end
      case ({push, pop_entry})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign bus.waitrequest = full;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almost_full = (level >= AF_L);
  assign bus.level       = level;
  assign bus.overflow    = overflow;
  assign bus.data_out    = data_out;
  assign bus.data_valid  = data_valid;

endmodule
